// File: rtl/mpt_plb.sv
// mpt_plb: fully-associative permission lookaside buffer ahead of the MPT walker.
// Define MPT_PLB_PERF_CNT_EN to add the hit_cnt_o / miss_cnt_o counters.
package mpt_plb_pkg;
    localparam int XLEN     = 32;
    localparam int SDID_LEN = 6;

    typedef enum logic [2:0] {
        ALLOW_NONE = 3'b000,
        ALLOW_R    = 3'b001,
        ALLOW_W    = 3'b010,
        ALLOW_RW   = 3'b011,
        ALLOW_X    = 3'b100,
        ALLOW_RX   = 3'b101,
        ALLOW_WX   = 3'b110,
        ALLOW_RWX  = 3'b111
    } mpt_permissions_e;

    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'd0,
        ACCESS_READ  = 2'd1,
        ACCESS_WRITE = 2'd2,
        ACCESS_EXEC  = 2'd3
    } mpt_access_e;

    typedef struct packed {
        logic [XLEN-1:0] raw;
    } spa_t;

    typedef struct packed {
        logic [SDID_LEN-1:0] sdid;
        spa_t                spa;
        mpt_access_e         access;
    } plb_lookup_req_t;

    typedef struct packed {
        logic [SDID_LEN-1:0] sdid;
        spa_t                spa;
        mpt_permissions_e    perms;
    } plb_entry_t;
endpackage

module mpt_plb
    import mpt_plb_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int PAGE_SHIFT  = 12
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                flush_sdid_en_i,
    input  logic [SDID_LEN-1:0] flush_sdid_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  plb_lookup_req_t     req_i,
    output logic                rsp_valid_o,
    output logic                rsp_hit_o,
    output mpt_permissions_e    rsp_perms_o,
    output logic                rsp_allow_o,
    output logic                rsp_error_o,
    output logic                miss_valid_o,
    input  logic                miss_ready_i,
    output plb_lookup_req_t     miss_req_o,
    input  logic                fill_valid_i,
    input  plb_entry_t          fill_entry_i,
    input  logic                fill_error_i
`ifdef MPT_PLB_PERF_CNT_EN
    ,
    output logic [31:0]         hit_cnt_o,
    output logic [31:0]         miss_cnt_o
`endif
);
    localparam int IW = $clog2(NUM_ENTRIES);
    localparam int TW = XLEN - PAGE_SHIFT;

    typedef enum logic [1:0] {
        IDLE, LOOKUP, MISS_REQ, WAIT_FILL
    } state_e;

    state_e                r_state;
    plb_lookup_req_t       r_req;
    logic                  r_flush_seen;
    logic [NUM_ENTRIES-1:0] r_valid;
    logic [SDID_LEN-1:0]   r_sdid  [NUM_ENTRIES];
    logic [TW-1:0]         r_tag   [NUM_ENTRIES];
    mpt_permissions_e      r_perms [NUM_ENTRIES];
    logic [IW-1:0]         r_victim;
    logic                  r_rsp_valid;
    mpt_permissions_e      r_rsp_perms;
    logic                  r_rsp_allow;
    logic                  r_rsp_error;

    logic [TW-1:0]          w_req_pn;
    logic [TW-1:0]          w_fill_pn;
    logic [NUM_ENTRIES-1:0] w_lk_m;
    logic [NUM_ENTRIES-1:0] w_fill_m;
    logic [NUM_ENTRIES-1:0] w_fl_m;
    logic [IW-1:0]          w_lk_idx;
    logic [IW-1:0]          w_fill_idx;
    logic [IW-1:0]          w_free_idx;
    logic [IW-1:0]          w_alloc;
    logic                   w_hit;
    logic                   w_fill;
    logic                   w_wr;
    logic                   w_rr;
    mpt_permissions_e       w_hit_perms;
    logic                   w_unused;

    function automatic logic f_allow(
        input mpt_access_e      a,
        input mpt_permissions_e p
    );
        logic [2:0] v;
        v = p;
        unique case (a)
            ACCESS_READ:  f_allow = v[0];
            ACCESS_WRITE: f_allow = v[1];
            ACCESS_EXEC:  f_allow = v[2];
            default:      f_allow = 1'b0;
        endcase
    endfunction

    assign w_req_pn  = r_req.spa.raw[XLEN-1:PAGE_SHIFT];
    assign w_fill_pn = fill_entry_i.spa.raw[XLEN-1:PAGE_SHIFT];
    assign w_unused  = ^fill_entry_i.spa.raw[PAGE_SHIFT-1:0];

    // Descending scan so the lowest matching index wins.
    always_comb begin
        w_lk_m     = '0;
        w_fill_m   = '0;
        w_fl_m     = '0;
        w_lk_idx   = '0;
        w_fill_idx = '0;
        w_free_idx = '0;
        for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
            w_lk_m[i]   = r_valid[i]
                       && r_sdid[i] == r_req.sdid
                       && r_tag[i] == w_req_pn;
            w_fill_m[i] = r_valid[i]
                       && r_sdid[i] == fill_entry_i.sdid
                       && r_tag[i] == w_fill_pn;
            w_fl_m[i]   = !flush_sdid_en_i
                       || r_sdid[i] == flush_sdid_i;
            if (w_lk_m[i])   w_lk_idx   = IW'(i);
            if (w_fill_m[i]) w_fill_idx = IW'(i);
            if (!r_valid[i]) w_free_idx = IW'(i);
        end
    end

    assign w_hit  = (r_state == LOOKUP) && (|w_lk_m) && !flush_i;
    assign w_fill = (r_state == WAIT_FILL) && fill_valid_i;
    assign w_wr   = w_fill && !fill_error_i
                 && !flush_i && !r_flush_seen;
    assign w_rr   = !(|w_fill_m) && (&r_valid);
    assign w_alloc = (|w_fill_m) ? w_fill_idx
                   : (w_rr ? r_victim : w_free_idx);

    assign w_hit_perms = r_perms[w_lk_idx];

    assign req_ready_o  = (r_state == IDLE) && !flush_i;
    assign miss_valid_o = (r_state == MISS_REQ);
    assign miss_req_o   = r_req;
    assign rsp_valid_o  = w_hit || r_rsp_valid;
    assign rsp_hit_o    = w_hit;
    assign rsp_perms_o  = w_hit ? w_hit_perms : r_rsp_perms;
    assign rsp_allow_o  = w_hit ? f_allow(r_req.access, w_hit_perms)
                                : r_rsp_allow;
    assign rsp_error_o  = !w_hit && r_rsp_error;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_req        <= '0;
            r_flush_seen <= 1'b0;
            r_valid      <= '0;
            r_victim     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_perms  <= ALLOW_R;
            r_rsp_allow  <= 1'b0;
            r_rsp_error  <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_sdid[i]  <= '0;
                r_tag[i]   <= '0;
                r_perms[i] <= ALLOW_NONE;
            end
        end else begin
            r_rsp_valid <= w_fill;
            r_rsp_allow <= w_fill && !fill_error_i
                        && f_allow(r_req.access, fill_entry_i.perms);
            r_rsp_error <= w_fill && fill_error_i;
            if (w_fill) r_rsp_perms <= fill_entry_i.perms;

            if (flush_i) begin
                r_valid <= r_valid & ~w_fl_m;
            end else if (w_wr) begin
                r_valid[w_alloc] <= 1'b1;
                r_sdid[w_alloc]  <= fill_entry_i.sdid;
                r_tag[w_alloc]   <= w_fill_pn;
                r_perms[w_alloc] <= fill_entry_i.perms;
                if (w_rr) r_victim <= r_victim + IW'(1);
            end

            unique case (r_state)
                IDLE: begin
                    if (req_valid_i && !flush_i) begin
                        r_req   <= req_i;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    r_flush_seen <= 1'b0;
                    r_state      <= w_hit ? IDLE : MISS_REQ;
                end
                MISS_REQ: begin
                    if (flush_i)      r_flush_seen <= 1'b1;
                    if (miss_ready_i) r_state      <= WAIT_FILL;
                end
                WAIT_FILL: begin
                    if (flush_i)      r_flush_seen <= 1'b1;
                    if (fill_valid_i) r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MPT_PLB_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
            if (miss_valid_o && miss_ready_i)
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif
endmodule

// File: tb/tb_mpt_plb.sv
// tb_mpt_plb: randomized scoreboard bench for mpt_plb with an
// entry-list reference model and a walker responder.
module tb_mpt_plb;
    import mpt_plb_pkg::*;

    localparam int NE = 8;
    localparam int PS = 12;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             flush_sel;
    logic [5:0]       flush_sdid;
    logic             req_valid;
    logic             req_ready;
    plb_lookup_req_t  req;
    logic             rsp_valid;
    logic             rsp_hit;
    mpt_permissions_e rsp_perms;
    logic             rsp_allow;
    logic             rsp_error;
    logic             miss_valid;
    logic             miss_ready;
    plb_lookup_req_t  miss_req;
    logic             fill_valid;
    plb_entry_t       fill_entry;
    logic             fill_err;
`ifdef MPT_PLB_PERF_CNT_EN
    logic [31:0]      hit_cnt;
    logic [31:0]      miss_cnt;
`endif

    mpt_plb #(.NUM_ENTRIES(NE), .PAGE_SHIFT(PS)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .flush_sdid_en_i (flush_sel),
        .flush_sdid_i    (flush_sdid),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_i           (req),
        .rsp_valid_o     (rsp_valid),
        .rsp_hit_o       (rsp_hit),
        .rsp_perms_o     (rsp_perms),
        .rsp_allow_o     (rsp_allow),
        .rsp_error_o     (rsp_error),
        .miss_valid_o    (miss_valid),
        .miss_ready_i    (miss_ready),
        .miss_req_o      (miss_req),
        .fill_valid_i    (fill_valid),
        .fill_entry_i    (fill_entry),
        .fill_error_i    (fill_err)
`ifdef MPT_PLB_PERF_CNT_EN
        ,
        .hit_cnt_o       (hit_cnt),
        .miss_cnt_o      (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit               hit;
        mpt_permissions_e perms;
        bit               allow;
        bit               err;
        bit               chk_lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: list of cached pages with a rotating victim slot.
    bit               m_v  [NE];
    logic [5:0]       m_s  [NE];
    logic [19:0]      m_p  [NE];
    mpt_permissions_e m_pm [NE];
    int               m_vic;
    int               m_hits;
    int               m_misses;

    function automatic void m_reset();
        for (int i = 0; i < NE; i++) m_v[i] = 1'b0;
        m_vic    = 0;
        m_hits   = 0;
        m_misses = 0;
    endfunction

    function automatic int m_find(input logic [5:0] s,
                                  input logic [19:0] p);
        for (int i = 0; i < NE; i++)
            if (m_v[i] && m_s[i] == s && m_p[i] == p) return i;
        return -1;
    endfunction

    function automatic void m_install(input logic [5:0] s,
                                      input logic [19:0] p,
                                      input mpt_permissions_e pm);
        int k;
        k = m_find(s, p);
        if (k < 0)
            for (int i = NE-1; i >= 0; i--) if (!m_v[i]) k = i;
        if (k < 0) begin
            k     = m_vic;
            m_vic = (m_vic + 1) % NE;
        end
        m_v[k]  = 1'b1;
        m_s[k]  = s;
        m_p[k]  = p;
        m_pm[k] = pm;
    endfunction

    function automatic void m_flush(input bit sel,
                                    input logic [5:0] s);
        for (int i = 0; i < NE; i++)
            if (!sel || m_s[i] == s) m_v[i] = 1'b0;
    endfunction

    function automatic bit m_allow(input mpt_access_e a,
                                   input mpt_permissions_e p);
        case (a)
            ACCESS_READ:
                return p inside {ALLOW_R, ALLOW_RW, ALLOW_RX, ALLOW_RWX};
            ACCESS_WRITE:
                return p inside {ALLOW_W, ALLOW_RW, ALLOW_WX, ALLOW_RWX};
            ACCESS_EXEC:
                return p inside {ALLOW_X, ALLOW_RX, ALLOW_WX, ALLOW_RWX};
            default:
                return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", rsp_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_hit", rsp_hit, mon_e.hit);
                chk("rsp_perms", rsp_perms, mon_e.perms);
                chk("rsp_allow", rsp_allow, mon_e.allow);
                chk("rsp_error", rsp_error, mon_e.err);
                if (mon_e.chk_lat)
                    chk("hit_latency", cyc - acc_cyc + 1, 1);
            end
        end
    end

    task automatic walk(input plb_lookup_req_t rq,
                        input mpt_permissions_e fp,
                        input logic fe,
                        input int stall,
                        input int fdly,
                        input bit coll);
        chk("miss_req", miss_req, rq);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", miss_valid, 1);
            chk("stall_req", miss_req, rq);
            chk("busy_ready", req_ready, 0);
        end
        miss_ready = 1'b1;
        @(posedge clk);
        #1 miss_ready = 1'b0;
        m_misses++;
        repeat (fdly) @(posedge clk);
        #1;
        fill_entry.sdid    = rq.sdid;
        fill_entry.spa.raw = rq.spa.raw;
        fill_entry.perms   = fp;
        fill_err   = fe;
        fill_valid = 1'b1;
        flush      = coll;
        flush_sel  = 1'b0;
        @(posedge clk);
        #1;
        fill_valid = 1'b0;
        fill_err   = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic do_req(input logic [5:0] s,
                          input logic [31:0] spa,
                          input mpt_access_e acc,
                          input mpt_permissions_e fp,
                          input logic fe,
                          input int stall,
                          input int fdly,
                          input bit coll);
        int   k;
        exp_t e;
        bit   done;
        bit   ok;
        plb_lookup_req_t rq;
        rq.sdid    = s;
        rq.spa.raw = spa;
        rq.access  = acc;
        k = m_find(s, spa[31:PS]);
        if (k >= 0) begin
            e = '{1'b1, m_pm[k], m_allow(acc, m_pm[k]), 1'b0, 1'b1};
            m_hits++;
        end else begin
            e = '{1'b0, fp, fe ? 1'b0 : m_allow(acc, fp), fe, 1'b0};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req       = rq;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = req_ready;
        end
        if (!ok) begin
            chk("accept_timeout", req_ready, 1);
            req_valid = 1'b0;
            void'(exp_q.pop_back());
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (rsp_valid) done = 1'b1;
            else if (miss_valid) walk(rq, fp, fe, stall, fdly, coll);
        end
        if (!done) chk("rsp_timeout", rsp_valid, 1);
        if (k < 0) begin
            if (coll)     m_flush(1'b0, '0);
            else if (!fe) m_install(s, spa[31:PS], fp);
        end
    endtask

    task automatic do_flush(input bit sel, input logic [5:0] s);
        @(posedge clk);
        #1;
        flush      = 1'b1;
        flush_sel  = sel;
        flush_sdid = s;
        @(negedge clk);
        chk("flush_ready", req_ready, 0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        flush_sel = 1'b0;
        m_flush(sel, s);
    endtask

    function automatic logic [31:0] pg(input int n);
        return 32'h8000_0000 + (n << PS);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        flush_sel  = 1'b0;
        flush_sdid = '0;
        req_valid  = 1'b0;
        req        = '0;
        miss_ready = 1'b0;
        fill_valid = 1'b0;
        fill_entry = '0;
        fill_err   = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_hit", rsp_hit, 0);
        chk("rst_rsp_perms", rsp_perms, ALLOW_R);
        chk("rst_rsp_allow", rsp_allow, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_miss_valid", miss_valid, 0);
        chk("rst_miss_req", miss_req, 0);
        rst_n = 1'b1;

        // cold miss then hit
        do_req(3, 32'h8000_1000, ACCESS_READ, ALLOW_RW, 0, 0, 1, 0);
        do_req(3, 32'h8000_1000, ACCESS_READ, ALLOW_NONE, 0, 0, 0, 0);
        // permission denial and exec
        do_req(4, pg(2), ACCESS_READ, ALLOW_R, 0, 1, 0, 0);
        do_req(4, pg(2), ACCESS_WRITE, ALLOW_NONE, 0, 0, 0, 0);
        do_req(4, pg(3), ACCESS_EXEC, ALLOW_X, 0, 0, 2, 0);
        do_req(4, pg(3), ACCESS_EXEC, ALLOW_NONE, 0, 0, 0, 0);

        // replacement over nine distinct pages
        do_flush(1'b0, '0);
        for (int i = 0; i < 9; i++)
            do_req(1, pg(16 + i), ACCESS_READ, ALLOW_RWX, 0, 0, 0, 0);
        for (int i = 1; i < 8; i++)
            do_req(1, pg(16 + i), ACCESS_WRITE, ALLOW_NONE, 0, 0, 0, 0);
        do_req(1, pg(16), ACCESS_READ, ALLOW_R, 0, 0, 0, 0);

        // selective flush
        do_flush(1'b0, '0);
        do_req(1, pg(40), ACCESS_READ, ALLOW_RW, 0, 0, 0, 0);
        do_req(2, pg(40), ACCESS_READ, ALLOW_RX, 0, 0, 0, 0);
        do_req(2, pg(41), ACCESS_READ, ALLOW_R, 0, 0, 0, 0);
        do_flush(1'b1, 6'd1);
        do_req(1, pg(40), ACCESS_READ, ALLOW_W, 0, 0, 0, 0);
        do_req(2, pg(40), ACCESS_EXEC, ALLOW_NONE, 0, 0, 0, 0);
        do_req(2, pg(41), ACCESS_READ, ALLOW_NONE, 0, 0, 0, 0);

        // flush collides with fill
        do_req(5, pg(50), ACCESS_READ, ALLOW_RW, 0, 0, 1, 1);
        do_req(5, pg(50), ACCESS_READ, ALLOW_R, 0, 0, 0, 0);

        // fault with a stalled walker
        do_req(6, pg(60), ACCESS_WRITE, ALLOW_RW, 1, 5, 1, 0);
        do_req(6, pg(60), ACCESS_WRITE, ALLOW_RW, 0, 0, 0, 0);

        // reset mid-walk, then a stray fill
        @(posedge clk);
        #1;
        req.sdid    = 6'd9;
        req.spa.raw = pg(70);
        req.access  = ACCESS_READ;
        req_valid   = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 10 && !miss_valid; c++) @(negedge clk);
        chk("mw_miss_valid", miss_valid, 1);
        miss_ready = 1'b1;
        @(posedge clk);
        #1 miss_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        chk("mw_rst_ready", req_ready, 1);
        chk("mw_rst_miss", miss_valid, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill_entry.sdid    = 6'd9;
        fill_entry.spa.raw = pg(70);
        fill_entry.perms   = ALLOW_RWX;
        fill_valid = 1'b1;
        @(posedge clk);
        #1 fill_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stray_fill", rsp_valid, 0);
        end
        do_req(9, pg(70), ACCESS_READ, ALLOW_R, 0, 0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 5) begin
                do_flush(1'($urandom_range(0, 1)),
                         6'($urandom_range(0, 3)));
            end else begin
                do_req(6'($urandom_range(0, 3)),
                       pg($urandom_range(0, 11)) |
                           32'($urandom_range(0, 4095)),
                       mpt_access_e'($urandom_range(0, 3)),
                       mpt_permissions_e'($urandom_range(0, 7)),
                       1'($urandom_range(0, 9) == 0),
                       $urandom_range(0, 3),
                       $urandom_range(0, 3),
                       $urandom_range(0, 19) == 0);
            end
        end

        repeat (5) @(negedge clk);
        chk("queue_drain", exp_q.size(), 0);
`ifdef MPT_PLB_PERF_CNT_EN
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_misses);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mpt_plb.md
# mpt_plb

Permission Lookaside Buffer for the Memory Protection Table unit. It sits directly upstream of the MPT walker. It accepts `plb_lookup_req_t` permission lookups and answers hits from a fully-associative cache of `plb_entry_t`. On a miss it forwards the request to the walker, then installs the returned leaf permissions. It also performs the final access-type check against the cached `mpt_permissions_e`.

## Interface

Parameters:
- `NUM_ENTRIES`, default 8: number of fully-associative entries; a power of two, at least 2.
- `PAGE_SHIFT`, default 12: log2(PAGESIZE); tag page number is `spa.raw[XLEN-1:PAGE_SHIFT]`.

Ports:
- `clk_i` — input, 1 bit: clock; single clock domain.
- `rst_ni` — input, 1 bit: asynchronous active-low reset.
- `flush_i` — input, 1 bit: invalidate all entries.
- `flush_sdid_en_i` — input, 1 bit: when high together with `flush_i`, invalidate only entries matching `flush_sdid_i`.
- `flush_sdid_i` — input, `SDID_LEN` bits: SDID for a selective flush.
- `req_valid_i` / `req_ready_o` — input / output, 1 bit each: lookup handshake.
- `req_i` — input, `plb_lookup_req_t`: SDID, SPA, access type.
- `rsp_valid_o` — output, 1 bit: one-cycle response strobe.
- `rsp_hit_o` — output, 1 bit: response was served from the cache.
- `rsp_perms_o` — output, `mpt_permissions_e`: permissions for the SPA.
- `rsp_allow_o` — output, 1 bit: the access type is permitted.
- `rsp_error_o` — output, 1 bit: the walker reported a fault.
- `miss_valid_o` / `miss_ready_i` — output / input, 1 bit each: walk request handshake to the MPT walker.
- `miss_req_o` — output, `plb_lookup_req_t`: registered copy of the missing request.
- `fill_valid_i` — input, 1 bit: walker result strobe.
- `fill_entry_i` — input, `plb_entry_t`: walker result (SDID, SPA, PERMS).
- `fill_error_i` — input, 1 bit: the walk ended in a page-format fault or access fault.
- `hit_cnt_o`, `miss_cnt_o` — output, 32 bits each: present only with `MPT_PLB_PERF_CNT_EN`.

## Operation

- FSM states: `IDLE`, `LOOKUP`, `MISS_REQ`, `WAIT_FILL`.
- **IDLE**
  - `req_ready_o = !flush_i`.
  - On handshake, latch `req_i` into `req_q` and go to `LOOKUP`.
- **LOOKUP**
  - Compare `req_q` against all valid entries. A hit requires SDID equal and page number equal.
  - On hit: assert `rsp_valid_o` and `rsp_hit_o=1`, drive the entry's PERMS, set `rsp_error_o=0`, go to `IDLE`.
  - On miss: go to `MISS_REQ`.
- **MISS_REQ**
  - `miss_valid_o=1` and `miss_req_o=req_q`, held stable until `miss_ready_i`.
  - On handshake, go to `WAIT_FILL`.
- **WAIT_FILL**
  - On `fill_valid_i`, pulse `rsp_valid_o` with `rsp_hit_o=0`, `rsp_perms_o=fill_entry_i.PERMS`, `rsp_error_o=fill_error_i`, then go to `IDLE`.
  - The entry is written only when `fill_error_i=0` and no flush was seen since the miss was issued (a `flush_seen` flag is set by any `flush_i` in `MISS_REQ`/`WAIT_FILL`).
- **Allow rule**
  - READ allowed iff PERMS[0]; WRITE iff PERMS[1]; EXEC iff PERMS[2].
  - ACCESS_NONE gives 0.
  - `rsp_error_o=1` forces `rsp_allow_o=0`.
- **Allocation**
  - If the fill matches an existing valid tag, overwrite that entry.
  - Otherwise use the lowest-index invalid entry.
  - Otherwise use the round-robin victim pointer, which then increments modulo `NUM_ENTRIES` (it wraps from `NUM_ENTRIES-1` to 0).
- **Flush**
  - Valid bits clear on the cycle after `flush_i`.
  - A flush during `LOOKUP` forces a miss.
  - A flush with a simultaneous fill lets the flush win: no write occurs, but the response is still delivered.

## Timing

- Reset values:
  - FSM in `IDLE`; all valid bits 0; victim pointer 0.
  - `req_ready_o=1`.
  - `rsp_valid_o=0`, `rsp_hit_o=0`, `rsp_perms_o=ALLOW_R` (0b001 encoding), `rsp_allow_o=0`, `rsp_error_o=0`.
  - `miss_valid_o=0`, `miss_req_o=0`.
  - Counters 0.
- Hit latency: `rsp_valid_o` is high in the cycle after request acceptance.
- Back-to-back throughput is one lookup per 2 cycles.
- Miss latency: 1 cycle plus the `miss` handshake, plus fill delay, plus 1 cycle; the response is registered in the cycle after `fill_valid_i`.
- The `miss` handshake is valid/ready. `miss_req_o` must not change while stalled.
- `fill_valid_i` outside `WAIT_FILL` is ignored.
- Reset asserted mid-walk returns the block to `IDLE` immediately. A later stray fill is ignored.
- Only one request is outstanding at a time; `req_ready_o=0` in all states except `IDLE`.

## Configuration

- `MPT_PLB_PERF_CNT_EN` defined:
  - `hit_cnt_o` increments on each hit response; `miss_cnt_o` increments on each `miss` handshake.
  - Both are 32-bit and wrap from 0xFFFF_FFFF to 0.
  - Both are cleared by reset only, not by flush.
- Not defined: the ports and counter logic are absent.

## Test plan

- **Cold miss then hit.** Request SDID=3, SPA=0x8000_1000, READ. Walker fill returns PERMS=ALLOW_RW.
  - First response: hit=0, allow=1.
  - Repeating the request gives hit=1, perms=ALLOW_RW, allow=1, 1-cycle latency.
- **Permission denial.**
  - A cached ALLOW_R entry with a WRITE request responds hit=1, allow=0.
  - ALLOW_X with EXEC responds allow=1.
- **Replacement.** With NUM_ENTRIES=8, fill 9 distinct pages, then request the first page again.
  - The first page misses (victim 0 evicted).
  - Pages 2-8 still hit.
- **Selective flush.** Cache entries for SDID 1 and SDID 2, then flush with `flush_sdid_en_i=1`, `flush_sdid_i=1`.
  - SDID-1 lookups miss.
  - SDID-2 lookups hit.
- **Flush and fill collide.** Assert `flush_i` in the same cycle as `fill_valid_i`.
  - The response is delivered.
  - The same request then misses again.
- **Fault and stall.**
  - Hold `miss_ready_i=0` for 5 cycles: `miss_req_o` stays stable.
  - Fill with `fill_error_i=1`: the response has error=1 and allow=0, nothing is cached, and the next identical request misses.
